// File: rtl/cpu_sequencer.sv
// Control sequencer for the accumulator CPU: fetch / decode / operand / execute FSM
// with memory handshake, retire counter and a sticky memory-timeout error state.
module cpu_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [2:0]       op_i,
  input  logic             z_i,
  input  logic             c_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             ir_ld_o,
  output logic             pc_inc_o,
  output logic             pc_ld_o,
  output logic             jmp_o,
  output logic             wr_o,
  output logic             wm_o,
  output logic             wf_o,
  output logic             alu_o,
  output logic             alux_o,
  output logic             ldi_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StOper   = 3'd3,
    StExec   = 3'd4,
    StError  = 3'd5
  } state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpLda = 3'b010;
  localparam logic [2:0] OpSta = 3'b011;
  localparam logic [2:0] OpJmp = 3'b100;
  localparam logic [2:0] OpJz  = 3'b101;
  localparam logic [2:0] OpJc  = 3'b110;
  localparam logic [2:0] OpLdi = 3'b111;

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW:0] TimeoutVal = MEM_TIMEOUT[TW:0];

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [TW:0]      tcnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             timeout_hit;

  assign tcnt_inc    = {1'b0, tcnt_q} + {{TW{1'b0}}, 1'b1};
  assign timeout_hit = (MEM_TIMEOUT != 0) && (tcnt_inc >= TimeoutVal);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = '0;
    retire    = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_ld_o   = 1'b0;
    pc_inc_o  = 1'b0;
    pc_ld_o   = 1'b0;
    jmp_o     = 1'b0;
    wr_o      = 1'b0;
    wm_o      = 1'b0;
    wf_o      = 1'b0;
    alu_o     = 1'b0;
    alux_o    = 1'b0;
    ldi_o     = 1'b0;
    err_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i || step_i) state_d = StFetch;
      end
      StFetch: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_ld_o  = 1'b1;
          pc_inc_o = 1'b1;
          state_d  = StDecode;
        end else if (timeout_hit) begin
          state_d = StError;
        end else begin
          tcnt_d = tcnt_inc[TW-1:0];
        end
      end
      StDecode: begin
        // Opcodes 1xx need no operand access.
        state_d = op_i[2] ? StExec : StOper;
      end
      StOper: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op_i == OpSta);
        if (mem_ack_i) begin
          retire = 1'b1;
          case (op_i)
            OpAdd:   begin wr_o = 1'b1; wf_o = 1'b1; end
            OpSub:   begin alu_o = 1'b1; wr_o = 1'b1; wf_o = 1'b1; end
            OpLda:   begin alux_o = 1'b1; wr_o = 1'b1; end
            OpSta:   wm_o = 1'b1;
            default: ;
          endcase
        end else if (timeout_hit) begin
          state_d = StError;
        end else begin
          tcnt_d = tcnt_inc[TW-1:0];
        end
      end
      StExec: begin
        retire = 1'b1;
        case (op_i)
          OpJmp:   begin jmp_o = 1'b1; pc_ld_o = 1'b1; end
          OpJz:    begin jmp_o = 1'b1; pc_ld_o = z_i; end
          OpJc:    begin jmp_o = 1'b1; pc_ld_o = c_i; end
          OpLdi:   begin alux_o = 1'b1; wr_o = 1'b1; ldi_o = 1'b1; end
          default: ;
        endcase
      end
      StError: err_o = 1'b1;
      default: state_d = StIdle;
    endcase
    if (retire) state_d = run_i ? StFetch : StIdle;
  end

  assign cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign busy_o      = (state_q != StIdle) && (state_q != StError);
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table-driven instruction vectors with a
// strobe scoreboard, plus hand-written step, mid-instruction reset and timeout sequences.
module tb_cpu_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni, run_i, step_i, z_i, c_i, mem_ack_i;
  logic [2:0]  op_i;
  logic        mem_req_o, mem_we_o, ir_ld_o, pc_inc_o, pc_ld_o;
  logic        jmp_o, wr_o, wm_o, wf_o, alu_o, alux_o, ldi_o;
  logic [2:0]  state_o;
  logic        busy_o, err_o;
  logic [15:0] instr_cnt_o;

  cpu_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .step_i(step_i), .op_i(op_i),
    .z_i(z_i), .c_i(c_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .ir_ld_o(ir_ld_o), .pc_inc_o(pc_inc_o), .pc_ld_o(pc_ld_o),
    .jmp_o(jmp_o), .wr_o(wr_o), .wm_o(wm_o), .wf_o(wf_o), .alu_o(alu_o),
    .alux_o(alux_o), .ldi_o(ldi_o), .state_o(state_o), .busy_o(busy_o),
    .err_o(err_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {jmp, wr, wm, wf, alu, alux, ldi, pc_ld} and {mem_req, mem_we, ir_ld, pc_inc, busy, err}
  wire [7:0] strb = {jmp_o, wr_o, wm_o, wf_o, alu_o, alux_o, ldi_o, pc_ld_o};
  wire [5:0] ctl  = {mem_req_o, mem_we_o, ir_ld_o, pc_inc_o, busy_o, err_o};

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       c;
    int         fw;
    int         ow;
    logic       oper;
    logic       we;
    logic [7:0] strb;
  } vec_t;

  vec_t       tbl[11];
  vec_t       sta_v;
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cnt_exp  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string nm);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got strobes %0h", nm, strb);
    end else begin
      check(nm, {24'd0, strb}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Drives one instruction starting from its first FETCH cycle.
  task automatic do_instr(input vec_t v, input logic run);
    logic ack;
    exp_q.push_back(v.strb);
    for (int w = 0; w <= v.fw; w++) begin
      @(negedge clk_i);
      ack = (w == v.fw);
      run_i = run; step_i = 1'b0; op_i = v.op; z_i = v.z; c_i = v.c; mem_ack_i = ack;
      #1;
      if (w == 0) check("retired_count", {16'd0, instr_cnt_o}, cnt_exp);
      check("fetch_state", {29'd0, state_o}, 32'd1);
      check("fetch_ctl", {26'd0, ctl}, {26'd0, 2'b10, ack, ack, 2'b10});
      check("fetch_strb", {24'd0, strb}, 32'd0);
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("decode_state", {29'd0, state_o}, 32'd2);
    check("decode_ctl", {26'd0, ctl}, 32'b000010);
    check("decode_strb", {24'd0, strb}, 32'd0);
    if (v.oper) begin
      for (int w = 0; w <= v.ow; w++) begin
        @(negedge clk_i);
        ack = (w == v.ow);
        mem_ack_i = ack;
        #1;
        check("oper_state", {29'd0, state_o}, 32'd3);
        check("oper_ctl", {26'd0, ctl}, {26'd0, 1'b1, v.we, 4'b0010});
        if (ack) pop_check("oper_strb");
        else check("oper_strb_idle", {24'd0, strb}, 32'd0);
      end
    end else begin
      @(negedge clk_i);
      #1;
      check("exec_state", {29'd0, state_o}, 32'd4);
      check("exec_ctl", {26'd0, ctl}, 32'b000010);
      pop_check("exec_strb");
    end
    cnt_exp++;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              op      z     c     fw ow oper  we    strobes
    tbl[0]  = '{3'b111, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'b01000110};  // LDI
    tbl[1]  = '{3'b000, 1'b0, 1'b0, 1, 3, 1'b1, 1'b0, 8'b01010000};  // ADD, ack late
    tbl[2]  = '{3'b001, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 8'b01011000};  // SUB
    tbl[3]  = '{3'b010, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 8'b01000100};  // LDA
    tbl[4]  = '{3'b011, 1'b0, 1'b0, 0, 2, 1'b1, 1'b1, 8'b00100000};  // STA
    tbl[5]  = '{3'b100, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 8'b10000001};  // JMP
    tbl[6]  = '{3'b101, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 8'b10000001};  // JZ taken
    tbl[7]  = '{3'b101, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 8'b10000000};  // JZ not taken
    tbl[8]  = '{3'b110, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 8'b10000001};  // JC taken
    tbl[9]  = '{3'b110, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 8'b10000000};  // JC not taken
    tbl[10] = '{3'b111, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'b01000110};  // LDI, run drops
    sta_v   = '{3'b011, 1'b0, 1'b0, 0, 1, 1'b1, 1'b1, 8'b00100000};

    rst_ni = 1'b1; run_i = 1'b0; step_i = 1'b0; op_i = 3'b000;
    z_i = 1'b0; c_i = 1'b0; mem_ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("reset_state", {29'd0, state_o}, 32'd0);
    check("reset_ctl", {26'd0, ctl}, 32'd0);
    check("reset_strb", {24'd0, strb}, 32'd0);
    check("reset_cnt", {16'd0, instr_cnt_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Continuous run through the table; run drops during the last instruction.
    @(negedge clk_i);
    run_i = 1'b1;
    #1 check("idle_before_run", {29'd0, state_o}, 32'd0);
    for (int i = 0; i < 11; i++) do_instr(tbl[i], (i != 10));
    @(negedge clk_i);
    #1;
    check("idle_after_run", {29'd0, state_o}, 32'd0);
    check("cnt_after_run", {16'd0, instr_cnt_o}, cnt_exp);

    // Single step of a STA with run low.
    @(negedge clk_i);
    step_i = 1'b1;
    #1 check("idle_step", {29'd0, state_o}, 32'd0);
    do_instr(sta_v, 1'b0);
    @(negedge clk_i);
    #1;
    check("idle_after_step", {29'd0, state_o}, 32'd0);
    check("cnt_after_step", {16'd0, instr_cnt_o}, 32'd12);

    // Asynchronous reset while the operand request is outstanding.
    @(negedge clk_i); run_i = 1'b1; op_i = 3'b000;
    @(negedge clk_i); mem_ack_i = 1'b1;
    @(negedge clk_i); mem_ack_i = 1'b0;
    @(negedge clk_i);
    #1 check("oper_req_before_reset", {31'd0, mem_req_o}, 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("midreset_state", {29'd0, state_o}, 32'd0);
    check("midreset_ctl", {26'd0, ctl}, 32'd0);
    check("midreset_strb", {24'd0, strb}, 32'd0);
    check("midreset_cnt", {16'd0, instr_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; run_i = 1'b0;

    // Memory never acks the fetch: ERROR after 15 wait cycles, sticky.
    @(negedge clk_i);
    run_i = 1'b1; mem_ack_i = 1'b0;
    #1 check("idle_before_timeout", {29'd0, state_o}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      #1 check("timeout_wait_state", {29'd0, state_o}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      step_i = 1'b1; mem_ack_i = (i == 2);
      #1;
      check("error_state", {29'd0, state_o}, 32'd5);
      check("error_ctl", {26'd0, ctl}, 32'b000001);
      check("error_strb", {24'd0, strb}, 32'd0);
    end
    check("error_cnt", {16'd0, instr_cnt_o}, 32'd0);
    rst_ni = 1'b0; step_i = 1'b0; run_i = 1'b0; mem_ack_i = 1'b0;
    #1 check("error_cleared", {26'd0, ctl}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
